// File: rtl/image_filter_3x3_if.sv
// Pixel-stream bundle for image_filter_3x3: input beat handshake plus filtered output.
// IMGPROC_THRESH_EN adds the thresh input used for output binarisation.
interface image_filter_3x3_if #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned OUT_W = 4
);
  logic             pix_valid;
  logic             sof;
  logic [PIX_W-1:0] pix_in;
  logic [1:0]       mode;
`ifdef IMGPROC_THRESH_EN
  logic [OUT_W-1:0] thresh;
`endif
  logic             out_valid;
  logic             out_sof;
  logic [OUT_W-1:0] pix_out;

`ifdef IMGPROC_THRESH_EN
  modport master (output pix_valid, sof, pix_in, mode, thresh,
                  input  out_valid, out_sof, pix_out);
  modport slave  (input  pix_valid, sof, pix_in, mode, thresh,
                  output out_valid, out_sof, pix_out);
`else
  modport master (output pix_valid, sof, pix_in, mode,
                  input  out_valid, out_sof, pix_out);
  modport slave  (input  pix_valid, sof, pix_in, mode,
                  output out_valid, out_sof, pix_out);
`endif
endinterface

// File: rtl/image_filter_3x3.sv
// Streaming 3x3 convolution (bypass / Laplacian / sharpen / box) with border masking.
// Optional IMGPROC_THRESH_EN binarises the saturated result against a per-frame threshold.
module image_filter_3x3 #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned PIX_W = 4,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned SHIFT = 3
) (
  input logic             clock,
  input logic             reset,
  image_filter_3x3_if.slave bus
);
  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = 12;
  localparam int unsigned AccW = PIX_W + 5;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax  = '1;
  localparam logic [31:0]     OutMax  = (32'd1 << OUT_W) - 32'd1;

  logic [PIX_W-1:0] lb0_mem [IMG_W];
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic [ColW-1:0] col_q, col_d, col_eff;
  logic [RowW-1:0] row_q, row_d, row_eff;
  logic [1:0]      mode_q, mode_d, mode_eff;
  logic            inner;

  logic                   s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
  logic                   s1_inner_q, s1_inner_d;
  logic [1:0]             s1_mode_q, s1_mode_d;
  logic [PIX_W-1:0]       s1_ctr_q, s1_ctr_d;
  logic signed [AccW-1:0] s1_acc_q, s1_acc_d;
  logic signed [AccW-1:0] px [3][3];
  logic signed [AccW-1:0] s_all, nsew, ctr, acc;

  logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [OUT_W-1:0] pix_out_q, pix_out_d, res, sat;
  logic [AccW-1:0]  sh;

`ifdef IMGPROC_THRESH_EN
  logic [OUT_W-1:0] thresh_q, thresh_d, thresh_eff, s1_thresh_q, s1_thresh_d;
`endif

  // A sof beat is treated as (row 0, col 0) and carries the new frame's kernel.
  always_comb begin
    col_eff  = bus.sof ? '0 : col_q;
    row_eff  = bus.sof ? '0 : row_q;
    mode_eff = bus.sof ? bus.mode : mode_q;
    lb0_rd   = lb0_mem[col_eff];
    lb1_rd   = lb1_mem[col_eff];
    inner    = (row_eff >= RowW'(2)) && (32'(col_eff) >= 32'd2);
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    win_d    = win_q;
    if (bus.pix_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = bus.pix_in;
      mode_d      = mode_eff;
      if (col_eff == ColLast) begin
        col_d = '0;
        row_d = (row_eff == RowMax) ? row_eff : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
  end

`ifdef IMGPROC_THRESH_EN
  always_comb begin
    thresh_eff  = bus.sof ? bus.thresh : thresh_q;
    thresh_d    = bus.pix_valid ? thresh_eff : thresh_q;
    s1_thresh_d = bus.pix_valid ? thresh_eff : s1_thresh_q;
  end
`endif

  // Stage 1: kernel sum over the freshly shifted window.
  always_comb begin
    s_all = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px[i][j] = signed'(AccW'(win_d[i][j]));
        s_all    = s_all + px[i][j];
      end
    end
    ctr  = px[1][1];
    nsew = px[0][1] + px[2][1] + px[1][0] + px[1][2];
    case (mode_eff)
      2'd1:    acc = (ctr <<< 3) - (s_all - ctr);
      2'd2:    acc = (ctr <<< 2) + ctr - nsew;
      2'd3:    acc = s_all;
      default: acc = '0;
    endcase
    s1_valid_d = bus.pix_valid;
    s1_sof_d   = bus.pix_valid & bus.sof;
    s1_acc_d   = bus.pix_valid ? acc        : s1_acc_q;
    s1_ctr_d   = bus.pix_valid ? win_d[1][1] : s1_ctr_q;
    s1_mode_d  = bus.pix_valid ? mode_eff   : s1_mode_q;
    s1_inner_d = bus.pix_valid ? inner      : s1_inner_q;
  end

  // Stage 2: clamp negatives, shift, saturate (optionally binarise).
  always_comb begin
    sh  = s1_acc_q >>> SHIFT;
    sat = (32'(sh) > OutMax) ? OUT_W'(OutMax) : OUT_W'(sh);
    if (s1_mode_q == 2'd0) begin
      res = OUT_W'(s1_ctr_q);
    end else if (!s1_inner_q || s1_acc_q[AccW-1] || (s1_acc_q == '0)) begin
      res = '0;
    end else begin
`ifdef IMGPROC_THRESH_EN
      res = (sat >= s1_thresh_q) ? OUT_W'(OutMax) : '0;
`else
      res = sat;
`endif
    end
    out_valid_d = s1_valid_q;
    out_sof_d   = s1_sof_q;
    pix_out_d   = s1_valid_q ? res : pix_out_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_acc_q    <= '0;
      s1_ctr_q    <= '0;
      s1_mode_q   <= '0;
      s1_inner_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      pix_out_q   <= '0;
`ifdef IMGPROC_THRESH_EN
      thresh_q    <= '0;
      s1_thresh_q <= '0;
`endif
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_acc_q    <= s1_acc_d;
      s1_ctr_q    <= s1_ctr_d;
      s1_mode_q   <= s1_mode_d;
      s1_inner_q  <= s1_inner_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      pix_out_q   <= pix_out_d;
`ifdef IMGPROC_THRESH_EN
      thresh_q    <= thresh_d;
      s1_thresh_q <= s1_thresh_d;
`endif
    end
  end

  // Line buffers and window are not reset; the border rule masks stale contents.
  always_ff @(posedge clock) begin
    if (!reset && bus.pix_valid) begin
      lb0_mem[col_eff] <= bus.pix_in;
      lb1_mem[col_eff] <= lb0_rd;
    end
    win_q <= win_d;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.pix_out   = pix_out_q;
endmodule

// File: tb/tb_image_filter_3x3.sv
// Scoreboard bench for image_filter_3x3 on an 8x6 frame: driver pushes expectations,
// a negedge monitor pops and compares pixels, sof marks and the 2-cycle valid latency.
module tb_image_filter_3x3;
  localparam int unsigned IMG_W = 8;
  localparam int unsigned PIX_W = 4;
  localparam int unsigned OUT_W = 4;
  localparam int unsigned SHIFT = 3;
  localparam int          NR    = 6;

  typedef struct packed {
    logic [3:0] pix;
    logic       chk;
    logic       sof;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic started = 1'b0;
  logic [1:0] pv_hist;
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   img [NR][IMG_W];

  always #5 clock = ~clock;

  image_filter_3x3_if #(.PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();

  image_filter_3x3 #(
    .IMG_W(IMG_W),
    .PIX_W(PIX_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic exp_t model(input int m, input int r, input int c, input bit s);
    exp_t e;
    int ctr, all, nsew, sum;
    e.pix = '0;
    e.chk = 1'b1;
    e.sof = s;
    all   = 0;
    sum   = 0;
    if (m == 0) begin
      if (r >= 1 && c >= 1) e.pix = 4'(img[r-1][c-1]);
      else e.chk = 1'b0;
    end else if (r >= 2 && c >= 2) begin
      ctr = img[r-1][c-1];
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) all += img[r-2+i][c-2+j];
      nsew = img[r-2][c-1] + img[r][c-1] + img[r-1][c-2] + img[r-1][c];
      case (m)
        1:       sum = 9 * ctr - all;
        2:       sum = 5 * ctr - nsew;
        default: sum = all;
      endcase
      if (sum > 0) begin
        sum   = sum >>> SHIFT;
        e.pix = (sum > 15) ? 4'd15 : 4'(sum);
      end
    end
    return e;
  endfunction

  task automatic idle();
    @(posedge clock); #1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic beat(input int p, input bit s, input int m);
    @(posedge clock); #1;
    bus.pix_valid = 1'b1;
    bus.sof       = s;
    bus.pix_in    = 4'(p);
    bus.mode      = 2'(m);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    sbq.delete();
  endtask

  // fm: mode presented on the sof beat; mm: mode presented on every other beat.
  task automatic drive_frame(input int fm, input int mm, input bit stall,
                             input int sr, input int sc);
    bit s;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r == sr && c == sc) return;
        s = (r == 0 && c == 0);
        if (stall) idle();
        beat(img[r][c], s, s ? fm : mm);
        sbq.push_back(model(fm, r, c, s));
      end
    end
    idle();
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IMG_W; c++)
        case (kind)
          0:       img[r][c] = 5;
          1:       img[r][c] = (r == 3 && c == 3) ? 15 : 0;
          2:       img[r][c] = 15;
          default: img[r][c] = (r * 7 + c * 3 + r * c) % 16;
        endcase
  endtask

  always @(posedge clock) begin
    if (reset) pv_hist <= '0;
    else       pv_hist <= {pv_hist[0], bus.pix_valid};
  end

  always @(negedge clock) begin
    exp_t e;
    if (started && !reset) begin
      n_cmp++;
      if (bus.out_valid !== pv_hist[1]) begin
        n_err++;
        $display("FAIL latency: out_valid=%0b required=%0b at %0t", bus.out_valid, pv_hist[1],
                 $time);
      end
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: pix_out=%0d with empty scoreboard at %0t",
                   bus.pix_out, $time);
        end else begin
          e = sbq.pop_front();
          n_cmp++;
          if (bus.out_sof !== e.sof) begin
            n_err++;
            $display("FAIL out_sof: got=%0b required=%0b at %0t", bus.out_sof, e.sof, $time);
          end
          if (e.chk) begin
            n_cmp++;
            if (bus.pix_out !== e.pix) begin
              n_err++;
              $display("FAIL pix_out: got=%0d required=%0d at %0t", bus.pix_out, e.pix, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_in    = '0;
    bus.mode      = '0;
`ifdef IMGPROC_THRESH_EN
    bus.thresh    = '0;
`endif
    do_reset();
    @(negedge clock);
    n_cmp += 3;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got=%0b required=0", bus.out_valid);
    end
    if (bus.out_sof !== 1'b0) begin
      n_err++; $display("FAIL reset_out_sof: got=%0b required=0", bus.out_sof);
    end
    if (bus.pix_out !== '0) begin
      n_err++; $display("FAIL reset_pix_out: got=%0d required=0", bus.pix_out);
    end
    started = 1'b1;

    fill(0); drive_frame(1, 1, 1'b0, -1, -1);            // constant frame, Laplacian
    fill(1); drive_frame(1, 1, 1'b0, -1, -1);            // single bright pixel
    fill(2); drive_frame(3, 3, 1'b0, -1, -1);            // box blur saturation
    fill(3); drive_frame(2, 2, 1'b0, -1, -1);            // sharpen, unstalled
    drive_frame(2, 2, 1'b1, -1, -1);                     // sharpen, alternate stalls
    drive_frame(1, 0, 1'b0, -1, -1);                     // mid-frame mode change ignored
    drive_frame(0, 0, 1'b0, -1, -1);                     // bypass from next sof
    drive_frame(3, 3, 1'b0, 4, 5);                       // aborted by reset at (4,5)
    do_reset();
    repeat (3) idle();
    drive_frame(3, 3, 1'b0, -1, -1);

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 20) begin
      @(posedge clock);
      wait_cnt++;
    end
    @(negedge clock);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d outputs outstanding, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
